// File: rtl/id_fwd_stage.sv
// id_fwd_stage: decode/issue front end between IF and EX.
// Registers the IF->ID pc/valid pair, keeps a private copy of the instruction
// while the ID slot is stalled (the synchronous inst SRAM output moves on
// underneath a stall), resolves both source operands through a youngest-first
// forwarding network and turns load-use hazards into EX bubbles.
// Optional build macro: ID_FWD_PERF_CNT_EN adds saturating perf counters
// perf_lu_stall / perf_fwd_hit.
module id_fwd_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int PC_W    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_in,
    input  logic                        flush,
    input  logic                        if_valid,
    input  logic [PC_W-1:0]             if_pc,
    input  logic [31:0]                 inst_rdata,
    output logic [ADDR_W-1:0]           rf_raddr1,
    output logic [ADDR_W-1:0]           rf_raddr2,
    input  logic [DATA_W-1:0]           rf_rdata1,
    input  logic [DATA_W-1:0]           rf_rdata2,
    input  logic [NUM_FWD-1:0]          fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0]   fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
    input  logic [NUM_FWD-1:0]          fwd_pend,
    output logic                        ex_valid,
    output logic [PC_W-1:0]             ex_pc,
    output logic [31:0]                 ex_inst,
    output logic [DATA_W-1:0]           ex_src1,
    output logic [DATA_W-1:0]           ex_src2,
    output logic                        stallreq
`ifdef ID_FWD_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_lu_stall,
    output logic [31:0]                 perf_fwd_hit
`endif
);

    typedef enum logic {
        ST_LIVE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    typedef struct packed {
        logic              hit;
        logic              pend;
        logic [DATA_W-1:0] data;
    } res_t;

    // Youngest-first operand lookup: walking from oldest to youngest lets the
    // youngest matching source overwrite any older one.
    function automatic res_t resolve(
        input logic [ADDR_W-1:0]         s,
        input logic [DATA_W-1:0]         rf,
        input logic [NUM_FWD-1:0]        we,
        input logic [NUM_FWD*ADDR_W-1:0] waddr,
        input logic [NUM_FWD*DATA_W-1:0] wdata,
        input logic [NUM_FWD-1:0]        pend
    );
        res_t r;
        r.hit  = 1'b0;
        r.pend = 1'b0;
        r.data = rf;
        if (s == '0) begin
            r.data = '0;
        end else begin
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == s)) begin
                    r.hit  = 1'b1;
                    r.pend = pend[i];
                    r.data = wdata[i*DATA_W +: DATA_W];
                end
            end
        end
        return r;
    endfunction

    logic              r_id_valid;
    logic [PC_W-1:0]   r_id_pc;
    logic [31:0]       r_inst_hold;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_capture;
    logic [31:0]       w_inst;
    logic [ADDR_W-1:0] w_rs;
    logic [ADDR_W-1:0] w_rt;
    res_t              w_res1;
    res_t              w_res2;
    logic              w_stallreq;
    logic              w_issue;

    // ID register: flush kills, stall holds, otherwise take what IF presents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
        end else if (!stall_in) begin
            r_id_valid <= if_valid;
            r_id_pc    <= if_pc;
        end
    end

    // Instruction-source state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter HELD on the first edge of a stall of a live
    // instruction; any release or flush goes back to following the SRAM.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_LIVE: begin
                if (stall_in && r_id_valid && !flush) begin
                    w_state_nxt = ST_HELD;
                    w_capture   = 1'b1;
                end
            end
            ST_HELD: begin
                if (!stall_in || flush) begin
                    w_state_nxt = ST_LIVE;
                end
            end
            default: w_state_nxt = ST_LIVE;
        endcase
    end

    // Snapshot of the SRAM word taken on the edge the stall begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_hold <= '0;
        end else if (w_capture) begin
            r_inst_hold <= inst_rdata;
        end
    end

    // Decode, forwarding, hazard detection and issue gating.
    always_comb begin
        w_inst     = '0;
        if (r_id_valid) begin
            w_inst = (r_state == ST_HELD) ? r_inst_hold : inst_rdata;
        end
        w_rs       = ADDR_W'(w_inst[25:21]);
        w_rt       = ADDR_W'(w_inst[20:16]);
        w_res1     = resolve(w_rs, rf_rdata1, fwd_we, fwd_waddr, fwd_wdata, fwd_pend);
        w_res2     = resolve(w_rt, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata, fwd_pend);
        w_stallreq = r_id_valid & ((w_res1.hit & w_res1.pend) | (w_res2.hit & w_res2.pend));
        w_issue    = r_id_valid & ~w_stallreq & ~flush;
    end

    assign rf_raddr1 = w_rs;
    assign rf_raddr2 = w_rt;
    assign stallreq  = w_stallreq;
    assign ex_valid  = w_issue;
    assign ex_pc     = w_issue ? r_id_pc     : '0;
    assign ex_inst   = w_issue ? w_inst      : '0;
    assign ex_src1   = w_issue ? w_res1.data : '0;
    assign ex_src2   = w_issue ? w_res2.data : '0;

`ifdef ID_FWD_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + 33'(inc);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [31:0] r_perf_lu_stall;
    logic [31:0] r_perf_fwd_hit;
    logic [1:0]  w_hit_inc;

    assign w_hit_inc = w_issue ? (2'(w_res1.hit) + 2'(w_res2.hit)) : 2'd0;

    // Saturating counters: hazard cycles and forwarded operands actually issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_lu_stall <= '0;
            r_perf_fwd_hit  <= '0;
        end else begin
            r_perf_lu_stall <= sat_add(r_perf_lu_stall, {1'b0, w_stallreq});
            r_perf_fwd_hit  <= sat_add(r_perf_fwd_hit, w_hit_inc);
        end
    end

    assign perf_lu_stall = r_perf_lu_stall;
    assign perf_fwd_hit  = r_perf_fwd_hit;
`endif

endmodule
